// File: rtl/bridge_pkg.sv
// Shared definitions for the CPU-to-peripheral bridge: FSM encoding,
// default window map and interrupt vector width.
package bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam int IRQ_W = 6;

   localparam logic [31:0] DEV0_BASE = 32'h0000_7f00;
   localparam logic [31:0] DEV1_BASE = 32'h0000_7f10;
   localparam logic [31:0] DEV2_BASE = 32'h0000_7f20;
   localparam logic [95:0] DEF_DEV_BASE = {DEV2_BASE, DEV1_BASE, DEV0_BASE};

endpackage

// File: rtl/bridge_decode.sv
// Address decoder: one-hot window hit (lowest index wins on overlap) plus miss flag.
module bridge_decode
   import bridge_pkg::*;
#(
   parameter int                 NDEV     = 3,
   parameter logic [NDEV*32-1:0] DEV_BASE = DEF_DEV_BASE[NDEV*32-1:0],
   parameter int                 WIN_BITS = 4
) (
   input  logic [31:0]     addr,
   output logic [NDEV-1:0] hit,
   output logic            miss
);

   always_comb begin
      hit  = '0;
      miss = 1'b1;
      // Scan downward so the lowest matching index is the one left standing
      for (int i = NDEV - 1; i >= 0; i--) begin
         if (addr[31:WIN_BITS] == DEV_BASE[i*32+WIN_BITS +: 32-WIN_BITS]) begin
            hit    = '0;
            hit[i] = 1'b1;
            miss   = 1'b0;
         end
      end
   end

endmodule

// File: rtl/sys_bridge.sv
// CPU request/ready bus to NDEV memory-mapped peripheral windows, with
// ack timeout, bus-error reporting and a registered interrupt vector.
module sys_bridge
   import bridge_pkg::*;
#(
   parameter int                 NDEV     = 3,
   parameter logic [NDEV*32-1:0] DEV_BASE = DEF_DEV_BASE[NDEV*32-1:0],
   parameter int                 WIN_BITS = 4,
   parameter int                 TIMEOUT  = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [31:0]           cpu_addr,
   input  logic [3:0]            cpu_be,
   input  logic [31:0]           cpu_wdata,
   output logic                  cpu_ready,
   output logic                  cpu_err,
   output logic [31:0]           cpu_rdata,
   output logic [NDEV-1:0]       dev_sel,
   output logic                  dev_we,
   output logic [WIN_BITS-3:0]   dev_addr,
   output logic [31:0]           dev_wdata,
   input  logic [NDEV*32-1:0]    dev_rdata,
   input  logic [NDEV-1:0]       dev_ack,
   input  logic [NDEV-1:0]       dev_irq,
   output logic [IRQ_W-1:0]      hwint
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic                we_q;
   logic [WIN_BITS-3:0] addr_q;
   logic [31:0]         wdata_q;

   logic [NDEV-1:0]     hit;
   logic                miss;
   logic                bad_req;
   logic                sel_ack;
   logic [31:0]         rd_mux;

   bridge_decode #(
      .NDEV     (NDEV),
      .DEV_BASE (DEV_BASE),
      .WIN_BITS (WIN_BITS)
   ) u_decode (
      .addr (cpu_addr),
      .hit  (hit),
      .miss (miss)
   );

   assign bad_req   = miss || (cpu_addr[1:0] != 2'b00) || (cpu_be != 4'b1111);
   assign sel_ack   = |(dev_ack & dev_sel);
   assign dev_addr  = addr_q;
   assign dev_wdata = wdata_q;

   // dev_sel doubles as the latched device index during ACCESS
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NDEV; i++) begin
         if (dev_sel[i]) rd_mux = rd_mux | dev_rdata[i*32 +: 32];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cpu_ready <= 1'b0;
         cpu_err   <= 1'b0;
         cpu_rdata <= '0;
         dev_sel   <= '0;
         dev_we    <= 1'b0;
      end else begin
         cpu_ready <= 1'b0;
         cpu_err   <= 1'b0;
         cpu_rdata <= '0;
         case (state)
            ST_IDLE: begin
               if (cpu_req) begin
                  if (bad_req) begin
                     state     <= ST_RESP;
                     cpu_ready <= 1'b1;
                     cpu_err   <= 1'b1;
                  end else begin
                     state   <= ST_ACCESS;
                     cnt     <= '0;
                     we_q    <= cpu_we;
                     addr_q  <= cpu_addr[WIN_BITS-1:2];
                     wdata_q <= cpu_wdata;
                     dev_sel <= hit;
                     dev_we  <= cpu_we;
                  end
               end
            end
            ST_ACCESS: begin
               if (sel_ack) begin
                  state     <= ST_RESP;
                  cpu_ready <= 1'b1;
                  cpu_rdata <= we_q ? 32'h0 : rd_mux;
                  dev_sel   <= '0;
                  dev_we    <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state     <= ST_RESP;
                  cpu_ready <= 1'b1;
                  cpu_err   <= 1'b1;
                  dev_sel   <= '0;
                  dev_we    <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) hwint <= '0;
      else        hwint <= IRQ_W'(dev_irq);
   end

endmodule

// File: doc/sys_bridge.md
SYS_BRIDGE -- requirements
Module: sys_bridge

Interface
REQ-001 Parameter NDEV, default 3: number of peripheral windows (1..8).
REQ-002 Parameter DEV_BASE, default {32'h7f20,32'h7f10,32'h7f00}: flattened NDEV*32 window base addresses, index 0 in the low word.
REQ-003 Parameter WIN_BITS, default 4: window size 2^WIN_BITS bytes; bases aligned to it.
REQ-004 Parameter TIMEOUT, default 15: maximum ACCESS cycles before bus error.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 cpu_req  in  1  CPU access request, held high until cpu_ready.
REQ-008 cpu_we  in  1  1=store, 0=load.
REQ-009 cpu_addr  in  32  byte address.
REQ-010 cpu_be  in  4  byte enables.
REQ-011 cpu_wdata  in  32  store data.
REQ-012 cpu_ready  out  1  one-cycle completion pulse.
REQ-013 cpu_err  out  1  bus error, valid with cpu_ready.
REQ-014 cpu_rdata  out  32  load data, valid with cpu_ready.
REQ-015 dev_sel  out  NDEV  one-hot device select.
REQ-016 dev_we  out  1  write strobe, qualified by dev_sel.
REQ-017 dev_addr  out  WIN_BITS-2  word offset in window (cpu_addr[WIN_BITS-1:2]).
REQ-018 dev_wdata  out  32  store data to device.
REQ-019 dev_rdata  in  NDEV*32  per-device read data, flattened.
REQ-020 dev_ack  in  NDEV  per-device completion.
REQ-021 dev_irq  in  NDEV  per-device interrupt level.
REQ-022 hwint  out  6  registered interrupt vector to CPU; bit i = dev_irq[i], unused bits 0.

Function
REQ-023 FSM states IDLE, ACCESS, RESP; one state per cycle minimum.
REQ-024 IDLE, cpu_req=1: decode hit = cpu_addr[31:WIN_BITS]==base[31:WIN_BITS]; overlapping hits resolved to lowest index.
REQ-025 IDLE: miss, cpu_addr[1:0]!=0, or cpu_be!=4'b1111 -> RESP with cpu_err=1; no dev_sel, no dev_we ever asserted.
REQ-026 IDLE: legal hit -> latch index, we, addr, wdata; go ACCESS; timeout counter cleared.
REQ-027 ACCESS: dev_sel one-hot for latched index, dev_we=latched we, dev_addr/dev_wdata from latches, all stable for the whole state.
REQ-028 ACCESS: dev_ack of selected device sampled high -> capture its dev_rdata (loads), go RESP, cpu_err=0; acks from unselected devices ignored.
REQ-029 ACCESS: counter increments each cycle without ack; counter==TIMEOUT-1 without ack -> RESP with cpu_err=1, cpu_rdata=0.
REQ-030 RESP: cpu_ready=1 exactly one cycle, dev_sel=0; next state IDLE.
REQ-031 Minimum latency: req sampled cycle 0, ACCESS cycle 1 with immediate ack, cpu_ready cycle 2; error responses ready cycle 1.
REQ-032 cpu_rdata=0 for stores and errors; holds captured value only during RESP, 0 otherwise.
REQ-033 cpu_addr/data changes after IDLE sampling have no effect on the in-flight access.
REQ-034 Back-to-back: cpu_req high in the IDLE cycle after RESP starts a new access; no idle gap beyond that.
REQ-035 hwint registered one cycle from dev_irq, independent of FSM.

Reset
REQ-036 reset low at a clock edge: state=IDLE, counter=0, latches=0, cpu_ready=0, cpu_err=0, cpu_rdata=0, dev_sel=0, dev_we=0, hwint=0.
REQ-037 Reset mid-ACCESS aborts without cpu_ready; a late dev_ack after reset is ignored.

Structure
REQ-038 Package bridge_pkg holds FSM state encoding, default base constants, and the IRQ width (6).
REQ-039 Sub-module bridge_decode: combinational address-to-one-hot hit plus miss flag, parametrised by NDEV, DEV_BASE, WIN_BITS.

Verification
REQ-040 Load 0x7f14, dev_ack[1] on first ACCESS cycle, dev_rdata[1]=0xDEADBEEF -> cpu_ready cycle 2, cpu_rdata=0xDEADBEEF, cpu_err=0, dev_sel=3'b010 for one cycle.
REQ-041 Store 0x7f04, wdata 0x12345678, ack after 3 cycles -> dev_we=1, dev_addr=1, dev_wdata=0x12345678 held 3 cycles, cpu_ready cycle 4, cpu_err=0.
REQ-042 Load 0x7f30 (miss), load 0x7f02 (unaligned), store 0x7f00 with be=4'b0011 -> each cpu_ready cycle 1, cpu_err=1, dev_sel never asserted.
REQ-043 Load 0x7f20, no ack -> cpu_ready with cpu_err=1 and cpu_rdata=0 after exactly 15 ACCESS cycles; dev_ack[0] asserted meanwhile ignored.
REQ-044 Reset low during ACCESS of 0x7f10 -> next cycle dev_sel=0, no cpu_ready; subsequent load completes normally.
REQ-045 dev_irq=3'b101 -> hwint=6'b000101 one cycle later; cleared with reset.
